arbitro_rr_demux: RTL and testbench

- Stage directly downstream of the 10-bit FIFO bank.
- Round-robin pops one word per cycle from four input FIFOs.
- Steers each word to one of four output FIFOs using the destination field in bits [9:8].
- Stalls all pops while any output FIFO reports almost_full.
- Keeps a per-destination word counter for the bench to check.

---
 rtl/arbitro_rr_demux_pkg.sv | 21 ++
 rtl/arbitro_rr_demux_if.sv | 33 +++
 rtl/arbitro_rr_demux_rr_arbiter4.sv | 28 ++
 rtl/arbitro_rr_demux.sv | 126 ++++++++++++
 tb/tb_arbitro_rr_demux.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_demux_pkg.sv
// Shared constants, FSM encoding and destination decode for the round-robin
// pop / destination demux stage behind the 10-bit FIFO bank.
package arbitro_rr_demux_pkg;

    localparam int DATA_W   = 10;
    localparam int NUM_Q    = 4;
    localparam int DEST_MSB = 9;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // Two-bit destination field whose upper bit sits at msb.
    function automatic logic [1:0] dest_of(input logic [DATA_W-1:0] word, input int msb);
        return 2'(word >> (msb - 1));
    endfunction

endpackage

// File: rtl/arbitro_rr_demux_if.sv
// Bus between the demux stage, the four input FIFOs and the four output FIFOs.
// master is the demux side; slave is the FIFO-bank side.
interface arbitro_rr_demux_if #(
    parameter int DATA_W = arbitro_rr_demux_pkg::DATA_W,
    parameter int NUM_Q  = arbitro_rr_demux_pkg::NUM_Q
);

    logic [NUM_Q-1:0]        fifo_empty;
    logic [NUM_Q*DATA_W-1:0] fifo_data;
    logic [NUM_Q-1:0]        pop;
    logic [NUM_Q-1:0]        out_almost_full;
    logic [NUM_Q-1:0]        push;
    logic [DATA_W-1:0]       data_out;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  out_almost_full,
        output pop,
        output push,
        output data_out
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output out_almost_full,
        input  pop,
        input  push,
        input  data_out
    );

endinterface

// File: rtl/arbitro_rr_demux_rr_arbiter4.sv
// Four-way round-robin grant: first requester at ptr, ptr+1, ... (mod 4).
// Purely combinational; the caller registers grant and next_ptr.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] next_ptr
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = idx + 2'd1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_demux.sv
// Round-robin pops one word per cycle from four input FIFOs and steers it to the
// output FIFO named by its destination field; pop->push latency is two cycles.
module arbitro_rr_demux #(
    parameter int DATA_W   = arbitro_rr_demux_pkg::DATA_W,
    parameter int NUM_Q    = arbitro_rr_demux_pkg::NUM_Q,
    parameter int DEST_MSB = arbitro_rr_demux_pkg::DEST_MSB,
    parameter int CNT_W    = arbitro_rr_demux_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    arbitro_rr_demux_if.master       bus,
    output logic [NUM_Q*CNT_W-1:0]   cnt_flat,
    output logic                     idle
);

    import arbitro_rr_demux_pkg::*;

    logic [NUM_Q-1:0]  req;
    logic [NUM_Q-1:0]  grant;
    logic [1:0]        ptr;
    logic [1:0]        next_ptr;
    logic              stall;
    logic              work;
    state_t            state;

    logic [NUM_Q-1:0]  pop_p0;
    logic              vld_p1;
    logic [NUM_Q-1:0]  sel_p1;
    logic [DATA_W-1:0] word_p1;
    logic [1:0]        dest_p1;
    logic [NUM_Q-1:0]  dest_oh_p1;
    logic [NUM_Q-1:0]  push_p2;
    logic [DATA_W-1:0] data_p2;
    logic [CNT_W-1:0]  cnt [NUM_Q];

    // fifo_empty must already account for a pop sampled on this same edge, so
    // a queue whose last word is being popped is never granted again.
    assign req   = ~bus.fifo_empty;
    assign work  = |req;
    assign stall = |bus.out_almost_full;

    rr_arbiter4 u_arb (
        .req      (req),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // Stage p0: arbitration FSM; pop is a registered one-hot grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            pop_p0 <= '0;
        end else begin
            if (stall) begin
                state  <= ST_STALL;
                pop_p0 <= '0;
            end else if (work) begin
                state  <= ST_ARB;
                pop_p0 <= grant;
                ptr    <= next_ptr;
            end else begin
                state  <= ST_IDLE;
                pop_p0 <= '0;
            end
        end
    end

    // Stage p1: remember which queue was popped; its data_out is valid now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            sel_p1 <= '0;
        end else begin
            vld_p1 <= |pop_p0;
            sel_p1 <= pop_p0;
        end
    end

    always_comb begin
        word_p1 = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            if (sel_p1[i]) begin
                word_p1 = word_p1 | bus.fifo_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign dest_p1 = dest_of(word_p1, DEST_MSB);

    always_comb begin
        dest_oh_p1          = '0;
        dest_oh_p1[dest_p1] = 1'b1;
    end

    // Stage p2: push to the destination FIFO and count it in the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_p2 <= '0;
            data_p2 <= '0;
            for (int d = 0; d < NUM_Q; d++) begin
                cnt[d] <= '0;
            end
        end else begin
            push_p2 <= vld_p1 ? dest_oh_p1 : '0;
            if (vld_p1) begin
                data_p2      <= word_p1;
                cnt[dest_p1] <= cnt[dest_p1] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int d = 0; d < NUM_Q; d++) begin
            cnt_flat[d*CNT_W +: CNT_W] = cnt[d];
        end
    end

    assign bus.pop      = pop_p0;
    assign bus.push     = push_p2;
    assign bus.data_out = data_p2;
    assign idle         = (state != ST_ARB) && !vld_p1 && !(|push_p2);

endmodule

// File: tb/tb_arbitro_rr_demux.sv
// Bench for arbitro_rr_demux: queue-based FIFO models upstream, a round-robin
// reference for pop, and a scoreboard of expected pushes drained by a monitor.
module tb_arbitro_rr_demux;

    localparam int DATA_W = 10;
    localparam int NUM_Q  = 4;
    localparam int CNT_W  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    arbitro_rr_demux_if #(.DATA_W(DATA_W), .NUM_Q(NUM_Q)) bus ();
    logic [NUM_Q*CNT_W-1:0] cnt_flat;
    logic                   idle;

    arbitro_rr_demux #(.DATA_W(DATA_W), .NUM_Q(NUM_Q), .DEST_MSB(9), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cnt_flat (cnt_flat),
        .idle     (idle)
    );

    typedef struct packed {
        logic [9:0] w;
        int         due;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [9:0] fq [4][$];
    int         occ [4]   = '{default: 0};
    logic [9:0] fdata [4] = '{default: '0};
    logic [3:0] af = '0;
    exp_t       sb [$];
    logic [3:0] exp_pop = '0;
    int         mptr = 0;
    logic [7:0] mcnt [4] = '{default: '0};
    int         pops_seen = 0;
    logic [3:0] pop_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Upstream FIFOs: empty looks ahead past a pop that this edge will consume.
    always_comb begin
        bus.fifo_empty = '0;
        bus.fifo_data  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.fifo_empty[i] = (occ[i] == 0) || (occ[i] == 1 && bus.pop[i]);
            bus.fifo_data[i*DATA_W +: DATA_W] = fdata[i];
        end
    end
    assign bus.out_almost_full = af;

    always @(posedge clk) begin
        logic [9:0] w;
        int         q;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (bus.pop[i]) begin
                chk("pop_nonempty_queue", fq[i].size() != 0, 1);
                if (fq[i].size() != 0) begin
                    w = fq[i].pop_front();
                    fdata[i] <= w;
                    sb.push_back('{w: w, due: cyc + 1});
                end
            end
        end
        for (int i = 0; i < 4; i++) occ[i] <= fq[i].size();
        // Reference: first non-empty queue from the model pointer, unless stalled.
        exp_pop = '0;
        if (!reset) begin
            mptr = 0;
        end else if (af == 4'b0) begin
            for (int k = 0; k < 4; k++) begin
                q = (mptr + k) % 4;
                if (!bus.fifo_empty[q]) begin
                    exp_pop[q] = 1'b1;
                    mptr       = (q + 1) % 4;
                    break;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("pop", bus.pop, exp_pop);
            chk("idle", idle, (exp_pop == 4'b0) && (sb.size() == 0));
            if (bus.pop != 4'b0) begin
                pops_seen++;
                pop_log.push_back(bus.pop);
            end
            if (bus.push != 4'b0) begin
                if (sb.size() == 0) begin
                    chk("push_unexpected", bus.push, 0);
                end else begin
                    e = sb.pop_front();
                    chk("push_dest", bus.push, 4'b0001 << e.w[9:8]);
                    chk("data_out", bus.data_out, e.w);
                    chk("push_latency", cyc, e.due);
                    mcnt[e.w[9:8]]++;
                end
            end else if (sb.size() != 0 && cyc >= sb[0].due) begin
                e = sb.pop_front();
                chk("push_missing", bus.push, 4'b0001 << e.w[9:8]);
            end
            for (int d = 0; d < 4; d++) chk("cnt", cnt_flat[d*CNT_W +: CNT_W], mcnt[d]);
        end
    end

    task automatic load(input int q, input logic [9:0] w);
        fq[q].push_back(w);
    endtask

    function automatic int fq_total();
        int t = 0;
        for (int i = 0; i < 4; i++) t += fq[i].size();
        return t;
    endfunction

    task automatic wait_idle(input int budget);
        int n    = 0;
        bit done = 1'b0;
        while (n < budget && !done) begin
            @(negedge clk);
            n++;
            if (idle && fq_total() == 0 && sb.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: idle=%0b queued=%0d after %0d cycles, expected idle=1 queued=0",
                     idle, fq_total(), n);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_pop", bus.pop, 0);
        chk("rst_push", bus.push, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_cnt", cnt_flat, 0);
        chk("rst_idle", idle, 1);
        sb.delete();
        exp_pop = '0;
        mptr    = 0;
        for (int d = 0; d < 4; d++) mcnt[d] = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("init_pop", bus.pop, 0);
        chk("init_push", bus.push, 0);
        chk("init_data_out", bus.data_out, 0);
        chk("init_cnt", cnt_flat, 0);
        chk("init_idle", idle, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single non-empty queue: one word to each destination, back to back.
        pops_seen = 0;
        for (int k = 0; k < 4; k++) load(2, 10'(k << 8));
        wait_idle(40);
        chk("single_pops", pops_seen, 4);
        chk("single_cnt", cnt_flat, {4{8'd1}});

        // Park the pointer at 0 (last grant to queue 3), then all four busy.
        load(3, 10'h0AA);
        wait_idle(20);
        pop_log.delete();
        for (int q = 0; q < 4; q++) begin
            load(q, 10'($urandom));
            load(q, 10'($urandom));
        end
        wait_idle(40);
        for (int k = 0; k < 5; k++) chk("rr_order", pop_log[k], 4'b0001 << (k % 4));

        // Backpressure from output FIFO 1 while words are in flight.
        for (int q = 0; q < 4; q++)
            for (int k = 0; k < 3; k++) load(q, 10'($urandom));
        repeat (3) @(negedge clk);
        af = 4'b0010;
        @(negedge clk);
        chk("bp_pop_stops", bus.pop, 0);
        chk("bp_inflight_push", bus.push != 4'b0, 1);
        repeat (4) @(negedge clk);
        chk("bp_stalled_idle", idle, 1);
        chk("bp_stalled_push", bus.push, 0);
        af = 4'b0000;
        @(negedge clk);
        chk("bp_resume", bus.pop != 4'b0, 1);
        wait_idle(40);

        // Drain to empty: one word in queues 0 and 3 only.
        pops_seen = 0;
        load(0, 10'($urandom));
        load(3, 10'($urandom));
        wait_idle(30);
        chk("drain_pops", pops_seen, 2);
        chk("drain_idle", idle, 1);

        // Random traffic with random almost_full pulses.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) load($urandom_range(0, 3), 10'($urandom));
            af = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
        end
        af = 4'b0;
        wait_idle(300);

        // Reset mid-stream with three words in flight; pointer restarts at 0.
        for (int q = 0; q < 4; q++)
            for (int k = 0; k < 4; k++) load(q, 10'($urandom));
        repeat (5) @(negedge clk);
        chk("rst_busy_before", idle, 0);
        pulse_reset();
        @(negedge clk);
        chk("rst_restart_ptr", bus.pop, 4'b0001);
        wait_idle(60);

        // Counter wrap: 256 words to destination 3 from a clean start.
        pulse_reset();
        for (int k = 0; k < 256; k++) load(k % 4, {2'b11, 8'(k)});
        wait_idle(600);
        chk("wrap_cnt3", cnt_flat[3*CNT_W +: CNT_W], 0);
        chk("wrap_others", cnt_flat[3*CNT_W-1:0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
